lector_contadores: RTL and testbench

//  Requester (initiator) side of the transaccion counter-readout handshake (req/idx -> data/valid).

---
 rtl/lector_contadores.sv | 167 ++++++++++++++++
 tb/tb_lector_contadores.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lector_contadores.sv
// Requester side of the counter-readout handshake. Reads NUM_COUNTERS word
// counters in order once the FIFO datapath is idle. It holds the captured values
// and their sum, and aborts a sequence whose responder stays silent too long.
module lector_contadores #(
    parameter int unsigned NUM_COUNTERS = 4,
    parameter int unsigned IDX_WIDTH    = 2,
    parameter int unsigned COUNT_WIDTH  = 5,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic                             clk,
    input  logic                             reset_L,
    input  logic                             init,
    input  logic                             start,
    input  logic                             idle,
    output logic                             req,
    output logic [IDX_WIDTH-1:0]             idx,
    input  logic [COUNT_WIDTH-1:0]           data,
    input  logic                             valid,
    output logic [COUNT_WIDTH-1:0]           count0,
    output logic [COUNT_WIDTH-1:0]           count1,
    output logic [COUNT_WIDTH-1:0]           count2,
    output logic [COUNT_WIDTH-1:0]           count3,
    output logic [COUNT_WIDTH+IDX_WIDTH-1:0] total,
    output logic                             counts_valid,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam int unsigned TOTAL_W = COUNT_WIDTH + IDX_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(NUM_COUNTERS - 1);
    localparam logic [7:0]           TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]             state_q, state_d;
    logic                   pending_q, pending_d;
    logic [7:0]             wait_q, wait_d;
    logic                   req_q, req_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [COUNT_WIDTH-1:0] cnt_q [NUM_COUNTERS];
    logic [COUNT_WIDTH-1:0] cnt_d [NUM_COUNTERS];
    logic [TOTAL_W-1:0]     total_q, total_d;
    logic                   cv_q, cv_d;
    logic                   busy_q, busy_d;
    logic                   to_q, to_d;
    logic [7:0]             wait_inc;

    assign wait_inc = wait_q + 8'd1;

    // Next-state logic: init overrides everything; otherwise the FSM step.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        wait_d    = wait_q;
        req_d     = req_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        cv_d      = cv_q;
        busy_d    = busy_q;
        to_d      = to_q;

        if (init) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            wait_d    = 8'd0;
            req_d     = 1'b0;
            idx_d     = '0;
            for (int i = 0; i < int'(NUM_COUNTERS); i++) cnt_d[i] = '0;
            total_d   = '0;
            cv_d      = 1'b0;
            busy_d    = 1'b0;
            to_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) pending_d = 1'b1;
                    // A start seen while the datapath is busy is remembered until idle.
                    if ((pending_q || start) && idle) begin
                        req_d     = 1'b1;
                        idx_d     = '0;
                        busy_d    = 1'b1;
                        cv_d      = 1'b0;
                        to_d      = 1'b0;
                        total_d   = '0;
                        pending_d = 1'b0;
                        wait_d    = 8'd0;
                        state_d   = WAIT;
                    end
                end
                WAIT: begin
                    // A valid on the expiry cycle takes priority over the timeout.
                    if (valid) begin
                        cnt_d[idx_q] = data;
                        total_d      = total_q + TOTAL_W'(data);
                        req_d        = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            cv_d    = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        wait_d = wait_inc;
                        if (wait_inc == TIMEOUT_CNT) begin
                            req_d   = 1'b0;
                            to_d    = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                GAP: begin
                    req_d   = 1'b1;
                    idx_d   = idx_q + IDX_WIDTH'(1);
                    wait_d  = 8'd0;
                    state_d = WAIT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            wait_q    <= 8'd0;
            req_q     <= 1'b0;
            idx_q     <= '0;
            for (int i = 0; i < int'(NUM_COUNTERS); i++) cnt_q[i] <= '0;
            total_q   <= '0;
            cv_q      <= 1'b0;
            busy_q    <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wait_q    <= wait_d;
            req_q     <= req_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            total_q   <= total_d;
            cv_q      <= cv_d;
            busy_q    <= busy_d;
            to_q      <= to_d;
        end
    end

    // Fixed count0..3 ports expose the first four counters.
    assign req          = req_q;
    assign idx          = idx_q;
    assign count0       = cnt_q[0];
    assign count1       = cnt_q[1];
    assign count2       = cnt_q[2];
    assign count3       = cnt_q[3];
    assign total        = total_q;
    assign counts_valid = cv_q;
    assign busy         = busy_q;
    assign timeout_err  = to_q;

endmodule

// File: tb/tb_lector_contadores.sv
// Randomized bench for lector_contadores. A behavioural responder answers each
// request after a chosen delay. The reference model predicts the captured counts,
// the total, the error flag, the request count and the edge count to completion.
module tb_lector_contadores;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset_L, init, start, idle, valid;
    logic [4:0] data;
    logic       req, counts_valid, busy, timeout_err;
    logic [1:0] idx;
    logic [4:0] count0, count1, count2, count3;
    logic [6:0] total;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] seq_d   [4];
    int         seq_dly [4];
    int         exp_cnt [4];

    lector_contadores #(
        .NUM_COUNTERS(4),
        .IDX_WIDTH   (2),
        .COUNT_WIDTH (5),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .init        (init),
        .start       (start),
        .idle        (idle),
        .req         (req),
        .idx         (idx),
        .data        (data),
        .valid       (valid),
        .count0      (count0),
        .count1      (count1),
        .count2      (count2),
        .count3      (count3),
        .total       (total),
        .counts_valid(counts_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_c0"}, count0, exp_cnt[0]);
        check({tag, "_c1"}, count1, exp_cnt[1]);
        check({tag, "_c2"}, count2, exp_cnt[2]);
        check({tag, "_c3"}, count3, exp_cnt[3]);
    endtask

    // Launch one sequence (optionally gated by idle=0 for gate_cycles edges),
    // act as responder, then compare against the model's prediction.
    task automatic run_seq(input int gate_cycles);
        int   abort_j, exp_edges, exp_total, exp_reqs, edges, nreq, cnt_r;
        logic req_prev, done;

        abort_j = -1; exp_edges = 0; exp_total = 0;
        for (int k = 0; k < 4; k++) begin
            if (abort_j < 0) begin
                if (seq_dly[k] >= TIMEOUT) begin
                    abort_j = k;
                    exp_edges += TIMEOUT;
                end else begin
                    exp_cnt[k] = int'(seq_d[k]);
                    exp_total += int'(seq_d[k]);
                    exp_edges += seq_dly[k] + 1 + ((k < 3) ? 1 : 0);
                end
            end
        end
        exp_reqs = (abort_j < 0) ? 4 : abort_j + 1;

        start = 1'b1;
        idle  = (gate_cycles == 0);
        @(negedge clk);
        start = 1'b0;
        if (gate_cycles > 0) begin
            for (int i = 1; i < gate_cycles; i++) @(negedge clk);
            check("gated_req", req, 0);
            check("gated_busy", busy, 0);
            idle = 1'b1;
            @(negedge clk);
        end
        check("accept_req", req, 1);
        check("accept_idx", idx, 0);
        check("accept_busy", busy, 1);
        check("accept_cv", counts_valid, 0);

        edges = 0; nreq = 0; cnt_r = 0; req_prev = 1'b0; done = 1'b0;
        while (!done && edges < 400) begin
            if (req) begin
                if (!req_prev) begin
                    cnt_r = 0;
                    check("req_idx", idx, nreq);
                    nreq++;
                end
                valid = (cnt_r == seq_dly[idx]);
                data  = valid ? seq_d[idx] : 5'($urandom);
                cnt_r++;
            end else begin
                // Strobes outside WAIT must be ignored.
                valid = 1'($urandom_range(0, 1));
                data  = 5'($urandom);
            end
            req_prev = req;
            @(negedge clk);
            edges++;
            if (!busy) done = 1'b1;
        end
        valid = 1'b0;

        check("seq_done", done, 1);
        check("seq_edges", edges, exp_edges);
        check("seq_reqs", nreq, exp_reqs);
        check("seq_req_low", req, 0);
        check("seq_cv", counts_valid, (abort_j < 0) ? 1 : 0);
        check("seq_timeout", timeout_err, (abort_j < 0) ? 0 : 1);
        check("seq_total", total, exp_total);
        check_counts("seq");
    endtask

    task automatic rand_seq();
        int r;
        for (int k = 0; k < 4; k++) begin
            seq_d[k] = 5'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7)      seq_dly[k] = $urandom_range(0, 3);
            else if (r < 9) seq_dly[k] = TIMEOUT - 1;
            else            seq_dly[k] = TIMEOUT + $urandom_range(0, 4);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        reset_L = 1'b0; init = 1'b0; start = 1'b0; idle = 1'b1;
        valid = 1'b0; data = 5'd0;
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
        repeat (2) @(negedge clk);
        check("rst_req", req, 0);
        check("rst_idx", idx, 0);
        check("rst_total", total, 0);
        check("rst_cv", counts_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_to", timeout_err, 0);
        check_counts("rst");
        reset_L = 1'b1;
        @(negedge clk);

        // Normal readout: 3,5,0,31 answered one cycle after req.
        seq_d = '{5'd3, 5'd5, 5'd0, 5'd31};
        seq_dly = '{1, 1, 1, 1};
        run_seq(0);

        // Start gated by a busy datapath for 10 cycles.
        rand_seq();
        seq_dly = '{1, 1, 1, 1};
        run_seq(10);

        // Silent responder on idx 2.
        rand_seq();
        seq_dly = '{1, 0, TIMEOUT + 3, 0};
        run_seq(0);

        // Valid on the expiry cycle is captured.
        rand_seq();
        seq_d[1] = 5'd7;
        seq_dly = '{0, TIMEOUT - 1, 2, 1};
        run_seq(0);

        // init while waiting on idx 1; concurrent and later strobes are discarded.
        start = 1'b1; idle = 1'b1;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1; data = 5'd11;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        check("init_pre_req", req, 1);
        check("init_pre_idx", idx, 1);
        init = 1'b1; valid = 1'b1; data = 5'd9;
        @(negedge clk);
        init = 1'b0;
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
        check("init_req", req, 0);
        check("init_idx", idx, 0);
        check("init_busy", busy, 0);
        check("init_total", total, 0);
        check("init_cv", counts_valid, 0);
        check_counts("init");
        @(negedge clk);
        valid = 1'b0;
        check("init_after_req", req, 0);
        check("init_after_total", total, 0);
        check_counts("init_after");

        // Asynchronous reset during GAP.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1; data = 5'd17;
        @(negedge clk);
        valid = 1'b0;
        check("gap_req", req, 0);
        check("gap_busy", busy, 1);
        check("gap_c0", count0, 17);
        reset_L = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
        check("arst_req", req, 0);
        check("arst_busy", busy, 0);
        check_counts("arst");
        @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        seq_d = '{5'd3, 5'd5, 5'd0, 5'd31};
        seq_dly = '{1, 1, 1, 1};
        run_seq(0);

        // Randomized sequences.
        for (int n = 0; n < 25; n++) begin
            rand_seq();
            run_seq(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
